// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl
// Reads a burst of words from an upstream FIFO and presents them as a
// valid/ready stream through a 2-entry skid buffer.
//
// Ports
//   rd_clk     : clock, all state changes on its rising edge
//   res_n      : asynchronous active-low reset
//   start      : burst request, sampled only while idle
//   burst_len  : words to read, latched when start is accepted
//   empty      : upstream FIFO empty flag
//   underflow  : upstream FIFO underflow flag (sets sticky err)
//   rdata      : upstream FIFO read data, valid one cycle after rd_en
//   rd_en      : upstream FIFO read strobe (combinational)
//   out_data   : stream data (head of the output buffer)
//   out_valid  : stream valid (output buffer non-empty)
//   out_ready  : stream ready from downstream
//   busy       : high in every state except IDLE
//   done       : one-cycle burst-complete pulse
//   rd_count   : words handed downstream in the current burst
//   err        : sticky underflow indication
module fifo_rd_ctrl #(
  parameter int DWIDTH = 8,
  parameter int LEN_W  = 5
) (
  input  logic              rd_clk,
  input  logic              res_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              empty,
  input  logic              underflow,
  input  logic [DWIDTH-1:0] rdata,
  output logic              rd_en,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  rd_count,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    issued_q, issued_d;
  logic [LEN_W-1:0]    rd_count_q, rd_count_d;
  logic                err_q, err_d;
  logic                in_flight_q, in_flight_d;
  logic [1:0]          occ_q, occ_d;
  logic [DWIDTH-1:0]   buf0_q, buf0_d;
  logic [DWIDTH-1:0]   buf1_q, buf1_d;

  logic                pop;
  logic                push;
  logic [1:0]          occ_after_pop;
  logic                rd_en_c;

  always_comb begin
    pop           = (occ_q != 2'd0) & out_ready;
    push          = in_flight_q;
    // Room is judged after this cycle's pop so a full-rate stream
    // (one word in the buffer, one in flight) keeps issuing every cycle.
    occ_after_pop = occ_q - {1'b0, pop};
    rd_en_c       = (state_q == S_READ) & ~empty & (issued_q < len_q) &
                    ((occ_after_pop + {1'b0, in_flight_q}) < 2'd2);

    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q + LEN_W'(rd_en_c);
    rd_count_d  = rd_count_q + LEN_W'(pop);
    err_d       = err_q | underflow;
    in_flight_d = rd_en_c;
    occ_d       = occ_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;

    // Output buffer: buf0 is always the head.
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = rdata;
        else               buf1_d = rdata;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        buf1_d = '0;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = rdata;
        end else begin
          buf0_d = buf1_q;
          buf1_d = rdata;
        end
      end
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d      = burst_len;
          issued_d   = '0;
          rd_count_d = '0;
          err_d      = underflow;
          state_d    = (burst_len != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        if (rd_count_d == len_q)     state_d = S_DONE;
        else if (issued_d == len_q)  state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (rd_count_d == len_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge res_n) begin
    if (!res_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      rd_count_q  <= '0;
      err_q       <= 1'b0;
      in_flight_q <= 1'b0;
      occ_q       <= '0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      rd_count_q  <= rd_count_d;
      err_q       <= err_d;
      in_flight_q <= in_flight_d;
      occ_q       <= occ_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

  assign rd_en     = rd_en_c;
  assign out_data  = buf0_q;
  assign out_valid = (occ_q != 2'd0);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign rd_count  = rd_count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed testbench for fifo_rd_ctrl with a behavioural upstream FIFO.
module tb_fifo_rd_ctrl;

  localparam int DW = 8;
  localparam int LW = 5;

  logic          rd_clk = 1'b0;
  logic          res_n;
  logic          start;
  logic [LW-1:0] burst_len;
  logic          empty = 1'b1;
  logic          underflow;
  logic [DW-1:0] rdata = '0;
  logic          rd_en;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic [LW-1:0] rd_count;
  logic          err;

  fifo_rd_ctrl #(.DWIDTH(DW), .LEN_W(LW)) dut (
    .rd_clk    (rd_clk),
    .res_n     (res_n),
    .start     (start),
    .burst_len (burst_len),
    .empty     (empty),
    .underflow (underflow),
    .rdata     (rdata),
    .rd_en     (rd_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .rd_count  (rd_count),
    .err       (err)
  );

  always #5 rd_clk = ~rd_clk;

  int            n_tot = 0;
  int            n_bad = 0;
  logic [7:0]    fq[$];
  logic [7:0]    rx[$];
  int            hs_cyc[$];
  logic          force_empty = 1'b0;
  logic          re_pend = 1'b0;
  int            cyc = 0;
  int            n_rden = 0;
  int            n_empty = 0;
  int            n_re_empty = 0;
  int            n_done = 0;
  int            done_cyc = 0;

  // Upstream FIFO model: pops on a sampled rd_en, data appears next cycle.
  always @(posedge rd_clk) begin
    #1;
    if (re_pend && fq.size() > 0) rdata = fq.pop_front();
    empty = force_empty || (fq.size() == 0);
    cyc++;
  end

  // Event monitor, sampled mid-cycle.
  always @(negedge rd_clk) begin
    re_pend = rd_en;
    if (res_n) begin
      if (rd_en) n_rden++;
      if (empty) n_empty++;
      if (empty && rd_en) n_re_empty++;
      if (out_valid && out_ready) begin
        rx.push_back(out_data);
        hs_cyc.push_back(cyc);
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge rd_clk);
    #2;
  endtask

  task automatic preload(input logic [7:0] first, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) fq.push_back(first + 8'(i));
  endtask

  task automatic begin_burst(input logic [LW-1:0] len);
    burst_len = len;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned budget);
    logic seen;
    seen = 1'b0;
    for (int unsigned k = 0; k < budget; k++) begin
      step();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, 32'(seen), 1);
  endtask

  task automatic check_words(input string tag, input int base, input logic [7:0] first,
                             input int n);
    logic [7:0] e;
    chk({tag, "_nwords"}, rx.size() - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < rx.size()) begin
        e = first + 8'(i);
        chk({tag, "_word"}, 32'(rx[base+i]), 32'(e));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_en"},     32'(rd_en),     0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_data"},  32'(out_data),  0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_done"},      32'(done),      0);
    chk({tag, "_rd_count"},  32'(rd_count),  0);
    chk({tag, "_err"},       32'(err),       0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_rx, b_re, b_dn, b_em, b_ree;

    res_n = 1'b0; start = 1'b0; burst_len = '0; underflow = 1'b0; out_ready = 1'b0;
    step(); step();
    check_all_zero("rst");
    res_n = 1'b1;
    step();

    // Basic burst of 4 at full rate.
    preload(8'h11, 4); out_ready = 1'b1; step();
    b_rx = rx.size(); b_re = n_rden; b_dn = n_done;
    begin_burst(5'd4);
    chk("t2_busy", 32'(busy), 1);
    chk("t2_rden_lat", 32'(rd_en), 1);
    chk("t2_ov_a", 32'(out_valid), 0);
    step();
    chk("t2_ov_b", 32'(out_valid), 0);
    step();
    chk("t2_ov_c", 32'(out_valid), 1);
    chk("t2_data0", 32'(out_data), 32'h11);
    wait_done("t2", 20);
    chk("t2_rdcnt", 32'(rd_count), 4);
    step();
    chk("t2_idle", 32'(busy), 0);
    check_words("t2", b_rx, 8'h11, 4);
    chk("t2_rden", n_rden - b_re, 4);
    chk("t2_ndone", n_done - b_dn, 1);
    if (rx.size() >= b_rx + 4) begin
      chk("t2_consec", hs_cyc[b_rx+3] - hs_cyc[b_rx], 3);
      chk("t2_done_lat", done_cyc - hs_cyc[b_rx+3], 1);
    end

    // Downstream stall.
    preload(8'h11, 4); out_ready = 1'b0; step();
    b_rx = rx.size(); b_re = n_rden;
    begin_burst(5'd4);
    repeat (6) step();
    chk("t3_stall_rden", n_rden - b_re, 2);
    chk("t3_hold_valid", 32'(out_valid), 1);
    chk("t3_hold_data", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    wait_done("t3", 20);
    chk("t3_rdcnt", 32'(rd_count), 4);
    step();
    check_words("t3", b_rx, 8'h11, 4);
    chk("t3_rden", n_rden - b_re, 4);

    // Upstream empty for 3 cycles mid-burst.
    preload(8'h21, 8); out_ready = 1'b1; step();
    b_rx = rx.size(); b_re = n_rden; b_em = n_empty; b_ree = n_re_empty;
    begin_burst(5'd8);
    step(); step();
    force_empty = 1'b1;
    repeat (3) step();
    force_empty = 1'b0;
    step();
    chk("t4_empty_cyc", n_empty - b_em, 3);
    wait_done("t4", 30);
    chk("t4_rdcnt", 32'(rd_count), 8);
    step();
    chk("t4_rden_empty", n_re_empty - b_ree, 0);
    check_words("t4", b_rx, 8'h21, 8);
    chk("t4_rden", n_rden - b_re, 8);

    // Zero-length burst.
    b_re = n_rden;
    begin_burst(5'd0);
    chk("t5_busy", 32'(busy), 1);
    chk("t5_done", 32'(done), 1);
    chk("t5_rden", 32'(rd_en), 0);
    step();
    chk("t5_idle", 32'(busy), 0);
    chk("t5_done_off", 32'(done), 0);
    chk("t5_nrden", n_rden - b_re, 0);

    // Second start while busy must not change the length.
    preload(8'h31, 4); out_ready = 1'b0; step();
    b_rx = rx.size(); b_re = n_rden;
    begin_burst(5'd4);
    step(); step();
    burst_len = 5'd2; start = 1'b1; step(); start = 1'b0;
    chk("t6_busy", 32'(busy), 1);
    step();
    out_ready = 1'b1;
    wait_done("t6", 20);
    chk("t6_rdcnt", 32'(rd_count), 4);
    step();
    check_words("t6", b_rx, 8'h31, 4);
    chk("t6_rden", n_rden - b_re, 4);

    // Reset mid-burst aborts without a done pulse.
    preload(8'h51, 4); out_ready = 1'b0; step();
    b_dn = n_done;
    begin_burst(5'd4);
    step(); step(); step();
    res_n = 1'b0;
    #1;
    check_all_zero("t6r");
    fq.delete();
    step(); step();
    res_n = 1'b1;
    step(); step();
    chk("t6r_ndone", n_done - b_dn, 0);
    chk("t6r_idle", 32'(busy), 0);
    preload(8'h41, 2); out_ready = 1'b1; step();
    b_rx = rx.size();
    begin_burst(5'd2);
    wait_done("t6n", 20);
    chk("t6n_rdcnt", 32'(rd_count), 2);
    step();
    check_words("t6n", b_rx, 8'h41, 2);

    // Sticky err from a single underflow pulse.
    chk("t7_err0", 32'(err), 0);
    underflow = 1'b1; step(); underflow = 1'b0;
    chk("t7_err_set", 32'(err), 1);
    step(); step();
    chk("t7_err_hold", 32'(err), 1);
    preload(8'h61, 1); step();
    chk("t7_err_hold2", 32'(err), 1);
    begin_burst(5'd1);
    chk("t7_err_clr", 32'(err), 0);
    wait_done("t7", 20);
    step();

    // Maximum length burst.
    preload(8'h80, 31); out_ready = 1'b1; step();
    b_rx = rx.size(); b_re = n_rden;
    begin_burst(5'd31);
    wait_done("t8", 80);
    chk("t8_rdcnt", 32'(rd_count), 31);
    step();
    chk("t8_rden", n_rden - b_re, 31);
    check_words("t8", b_rx, 8'h80, 31);
    if (rx.size() >= b_rx + 31)
      chk("t8_rate", hs_cyc[b_rx+30] - hs_cyc[b_rx], 30);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
